// File: rtl/reservation_station.sv
// Unified 5-entry reservation station.
// Holds renamed instruction packets until both source tags are ready, wakes tags from CDB
// broadcasts and issues at most one ready entry per cycle (lowest index first).
//
// Packet layout (PKT_W = 53 bits, MSB first):
//   [52:50] fu        ALU=0, MULT=1, LOAD=2, STORE=3, BRANCH=4
//   [49:18] inst      inst==0 is the no-op encoding (no allocation request)
//   [17:12] dest_tag  {reg_num[4:0], ready}
//   [11:6]  tag1      {reg_num[4:0], ready}
//   [5:0]   tag2      {reg_num[4:0], ready}
//
// Ports:
//   clock          system clock, all state on posedge
//   reset          asynchronous active-low reset
//   packet_in      incoming renamed packet
//   cdb_ready      CDB broadcast valid
//   cdb_tag        CDB tag {reg_num, ready}; only reg_num is compared
//   issue_enable   downstream FU can accept an instruction
//   free           per-entry release mask, applied at the next posedge
//   allocate_done  combinational: packet_in is written at the next posedge
//   ready_issue    registered: issued_packet/issue_index are valid
//   issued_packet  registered issued packet (zero when not issuing)
//   issue_index    registered entry index of the issued packet (zero when not issuing)
module reservation_station #(
  parameter int unsigned RS_SIZE = 5,
  parameter int unsigned IDX_W   = 5,
  parameter int unsigned PKT_W   = 53
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [PKT_W-1:0]   packet_in,
  input  logic               cdb_ready,
  input  logic [5:0]         cdb_tag,
  input  logic               issue_enable,
  input  logic [RS_SIZE-1:0] free,
  output logic               allocate_done,
  output logic               ready_issue,
  output logic [PKT_W-1:0]   issued_packet,
  output logic [IDX_W-1:0]   issue_index
);

  localparam int unsigned InstLsb = 18;
  localparam int unsigned InstMsb = 49;
  localparam int unsigned T1Rdy   = 6;
  localparam int unsigned T2Rdy   = 0;

  logic [RS_SIZE-1:0] valid_q, valid_d;
  logic [PKT_W-1:0]   pkt_q [RS_SIZE];
  logic [PKT_W-1:0]   pkt_d [RS_SIZE];

  logic               ready_issue_q, ready_issue_d;
  logic [PKT_W-1:0]   issued_packet_q, issued_packet_d;
  logic [IDX_W-1:0]   issue_index_q, issue_index_d;

  logic               alloc_req;
  logic               alloc_hit;
  logic [IDX_W-1:0]   alloc_idx;
  logic               issue_hit;
  logic [IDX_W-1:0]   issue_idx;
  logic [RS_SIZE-1:0] eligible;

  // The ready bit of the CDB tag carries no meaning for wakeup.
  logic unused_cdb_tag_rdy;
  assign unused_cdb_tag_rdy = cdb_tag[0];

  // Set the ready bit of any source tag whose reg_num matches the broadcast.
  function automatic logic [PKT_W-1:0] wake(input logic [PKT_W-1:0] p, input logic cv,
                                            input logic [4:0] cn);
    logic [PKT_W-1:0] r;
    r = p;
    if (cv && (p[11:7] == cn)) r[T1Rdy] = 1'b1;
    if (cv && (p[5:1] == cn)) r[T2Rdy] = 1'b1;
    return r;
  endfunction

  // Allocation target and issue selection both look only at current state, so entries
  // released at this edge are not reused until the following cycle.
  always_comb begin
    alloc_req = (packet_in[InstMsb:InstLsb] != '0);
    alloc_hit = 1'b0;
    alloc_idx = '0;
    issue_hit = 1'b0;
    issue_idx = '0;
    eligible  = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      eligible[i] = valid_q[i] && pkt_q[i][T1Rdy] && pkt_q[i][T2Rdy] && !free[i];
      if (!valid_q[i]) begin
        alloc_hit = 1'b1;
        alloc_idx = i[IDX_W-1:0];
      end
      if (eligible[i]) begin
        issue_hit = issue_enable;
        issue_idx = i[IDX_W-1:0];
      end
    end
  end

  assign allocate_done = alloc_req && alloc_hit;

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < RS_SIZE; i++) begin
      pkt_d[i] = pkt_q[i];
      if (free[i]) begin
        valid_d[i] = 1'b0;
      end else if (issue_hit && (issue_idx == i[IDX_W-1:0])) begin
        valid_d[i] = 1'b0;
      end else if (valid_q[i]) begin
        pkt_d[i] = wake(pkt_q[i], cdb_ready, cdb_tag[5:1]);
      end
      // Target is invalid in current state, so free/issue above cannot conflict with it.
      if (allocate_done && (alloc_idx == i[IDX_W-1:0])) begin
        valid_d[i] = 1'b1;
        pkt_d[i]   = wake(packet_in, cdb_ready, cdb_tag[5:1]);
      end
    end
  end

  always_comb begin
    ready_issue_d   = 1'b0;
    issued_packet_d = '0;
    issue_index_d   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (issue_hit && (issue_idx == i[IDX_W-1:0])) begin
        ready_issue_d   = 1'b1;
        issued_packet_d = pkt_q[i];
        issue_index_d   = issue_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q         <= '0;
      ready_issue_q   <= 1'b0;
      issued_packet_q <= '0;
      issue_index_q   <= '0;
      for (int i = 0; i < RS_SIZE; i++) pkt_q[i] <= '0;
    end else begin
      valid_q         <= valid_d;
      ready_issue_q   <= ready_issue_d;
      issued_packet_q <= issued_packet_d;
      issue_index_q   <= issue_index_d;
      for (int i = 0; i < RS_SIZE; i++) pkt_q[i] <= pkt_d[i];
    end
  end

  assign ready_issue   = ready_issue_q;
  assign issued_packet = issued_packet_q;
  assign issue_index   = issue_index_q;

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;

  typedef struct packed {
    logic [2:0]  fu;
    logic [31:0] inst;
    logic [4:0]  dn;
    logic        dr;
    logic [4:0]  n1;
    logic        r1;
    logic [4:0]  n2;
    logic        r2;
  } pkt_t;

  typedef struct {
    int   edge_no;
    pkt_t pkt;
    int   idx;
  } exp_t;

  localparam logic [2:0] FuAlu = 3'd0, FuMult = 3'd1, FuLoad = 3'd2, FuStore = 3'd3,
                         FuBranch = 3'd4;

  logic        clock = 1'b0;
  logic        reset;
  pkt_t        pkt_i;
  logic        cdb_v;
  logic [5:0]  cdb_tag;
  logic        ie;
  logic [4:0]  fr;
  logic        alloc_done;
  logic        rdy;
  logic [52:0] ipkt;
  logic [4:0]  iidx;

  reservation_station dut (
    .clock         (clock),
    .reset         (reset),
    .packet_in     (pkt_i),
    .cdb_ready     (cdb_v),
    .cdb_tag       (cdb_tag),
    .issue_enable  (ie),
    .free          (fr),
    .allocate_done (alloc_done),
    .ready_issue   (rdy),
    .issued_packet (ipkt),
    .issue_index   (iidx)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int edge_cnt = 0;

  // Reference model: a plain array of occupied slots.
  bit   m_v [5];
  pkt_t m_p [5];
  exp_t sb [$];

  always @(posedge clock) edge_cnt++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  function automatic pkt_t mk(input logic [2:0] fu, input int inst, input int dn,
                              input int n1, input bit r1, input int n2, input bit r2);
    pkt_t p;
    p.fu = fu; p.inst = inst; p.dn = dn[4:0]; p.dr = 1'b1;
    p.n1 = n1[4:0]; p.r1 = r1; p.n2 = n2[4:0]; p.r2 = r2;
    return p;
  endfunction

  function automatic pkt_t wake_pkt(input pkt_t p, input bit cv, input logic [4:0] cn);
    pkt_t r;
    r = p;
    if (cv && p.n1 == cn) r.r1 = 1'b1;
    if (cv && p.n2 == cn) r.r2 = 1'b1;
    return r;
  endfunction

  // Monitor: every issue the DUT presents is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (rdy === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_issue @edge %0d: got idx %0d pkt %0h expected no issue",
                   edge_cnt, iidx, ipkt);
        end else begin
          e = sb.pop_front();
          check("issue_edge", 64'(edge_cnt), 64'(e.edge_no));
          check("issued_packet", 64'(ipkt), 64'(e.pkt));
          check("issue_index", 64'(iidx), 64'(e.idx));
        end
      end else begin
        if (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
          n_vec++; n_err++;
          $display("FAIL missing_issue @edge %0d: got no issue expected idx %0d pkt %0h",
                   edge_cnt, sb[0].idx, sb[0].pkt);
          void'(sb.pop_front());
        end else begin
          check("idle_outputs", 64'({ipkt, iidx}), 64'd0);
        end
      end
    end
  end

  // Drive one cycle of inputs, check allocate_done, then advance the model over the edge.
  task automatic step(input pkt_t p, input bit cv, input int cn, input bit ie_v,
                      input logic [4:0] f);
    bit   any_free;
    int   tgt;
    int   k;
    bit   exp_alloc;
    exp_t e;
    @(negedge clock);
    pkt_i   = p;
    cdb_v   = cv;
    cdb_tag = {cn[4:0], 1'($urandom_range(0, 1))};
    ie      = ie_v;
    fr      = f;
    #1;
    any_free = 0;
    tgt = 0;
    for (int i = 4; i >= 0; i--) if (!m_v[i]) begin any_free = 1; tgt = i; end
    exp_alloc = (p.inst != 0) && any_free;
    check("allocate_done", 64'(alloc_done), 64'(exp_alloc));
    k = -1;
    if (ie_v) begin
      for (int i = 0; i < 5; i++) begin
        if (m_v[i] && m_p[i].r1 && m_p[i].r2 && !f[i]) begin k = i; break; end
      end
    end
    if (k >= 0) begin
      e.edge_no = edge_cnt + 1;
      e.pkt = m_p[k];
      e.idx = k;
      sb.push_back(e);
    end
    for (int i = 0; i < 5; i++) begin
      if (f[i] || i == k) m_v[i] = 0;
      else if (m_v[i]) m_p[i] = wake_pkt(m_p[i], cv, cn[4:0]);
    end
    if (exp_alloc) begin
      m_v[tgt] = 1;
      m_p[tgt] = wake_pkt(p, cv, cn[4:0]);
    end
  endtask

  task automatic idle(input bit ie_v, input int n);
    for (int i = 0; i < n; i++) step('0, 0, 0, ie_v, 5'b0);
  endtask

  initial begin
    pkt_t rp;
    pkt_i = '0; cdb_v = 0; cdb_tag = '0; ie = 0; fr = '0;
    for (int i = 0; i < 5; i++) begin m_v[i] = 0; m_p[i] = '0; end
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("reset_ready_issue", 64'(rdy), 64'd0);
    check("reset_outputs", 64'({ipkt, iidx}), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Fully ready LOAD issues the edge after allocation.
    step(mk(FuLoad, 54, 5, 0, 1, 4, 1), 0, 0, 1, 5'b0);
    idle(1, 2);
    // MULT waits for tag 5, issues the edge after the wakeup edge.
    step(mk(FuMult, 64, 6, 1, 1, 5, 0), 0, 0, 1, 5'b0);
    idle(1, 2);
    step('0, 1, 5, 1, 5'b0);
    idle(1, 2);
    // Allocation racing with a matching broadcast stores the tag ready.
    step(mk(FuAlu, 100, 7, 2, 1, 7, 0), 1, 7, 1, 5'b0);
    idle(1, 2);
    // Fill, overflow, free entry 1, refill it, then wake and drain.
    for (int i = 0; i < 5; i++) step(mk(FuStore, 200 + i, i, 10, 0, 11, 0), 0, 0, 0, 5'b0);
    step(mk(FuBranch, 300, 9, 1, 1, 1, 1), 0, 0, 1, 5'b0);
    step('0, 0, 0, 0, 5'b00010);
    step(mk(FuAlu, 400, 1, 12, 1, 13, 1), 0, 0, 0, 5'b0);
    step('0, 1, 10, 1, 5'b0);
    step('0, 1, 11, 1, 5'b0);
    idle(1, 7);
    // Two ready entries held back by issue_enable, then issued in index order.
    step(mk(FuAlu, 500, 3, 1, 1, 2, 1), 0, 0, 0, 5'b0);
    step(mk(FuMult, 501, 4, 20, 0, 21, 0), 0, 0, 0, 5'b0);
    step(mk(FuAlu, 502, 5, 3, 1, 4, 1), 0, 0, 0, 5'b0);
    idle(0, 2);
    idle(1, 3);
    step('0, 0, 0, 0, 5'b00010);
    idle(1, 1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      rp.fu   = 3'($urandom_range(0, 4));
      rp.inst = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rp.dn   = 5'($urandom_range(0, 31));
      rp.dr   = 1'($urandom_range(0, 1));
      rp.n1   = 5'($urandom_range(0, 7));
      rp.r1   = 1'($urandom_range(0, 1));
      rp.n2   = 5'($urandom_range(0, 7));
      rp.r2   = 1'($urandom_range(0, 1));
      step(rp, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 3) != 0,
           ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'b0);
    end

    // Asynchronous reset mid-operation, with an allocation pending.
    for (int i = 0; i < 5; i++) step(mk(FuAlu, 700 + i, i, 15, 0, 16, 0), 0, 0, 0, 5'b0);
    step(mk(FuLoad, 800, 2, 1, 1, 1, 1), 0, 0, 0, 5'b00001);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_ready_issue", 64'(rdy), 64'd0);
    check("async_reset_outputs", 64'({ipkt, iidx}), 64'd0);
    for (int i = 0; i < 5; i++) m_v[i] = 0;
    pkt_i = mk(FuAlu, 900, 1, 1, 1, 1, 1);
    ie = 1; fr = '0; cdb_v = 0;
    #1;
    check("reset_alloc_req", 64'(alloc_done), 64'd1);
    pkt_i = '0;
    #1;
    check("reset_alloc_noop", 64'(alloc_done), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    pkt_i = '0; ie = 1;
    idle(1, 4);
    step(mk(FuBranch, 901, 2, 3, 1, 3, 1), 0, 0, 1, 5'b0);
    idle(1, 3);

    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- 5-entry unified reservation station between decode/rename and the functional units.
- Each cycle it accepts at most one renamed instruction packet and holds it until both source operands are ready.
- Source tags wake up from CDB broadcasts.
- Each cycle it issues at most one ready instruction, lowest entry index first; entries can also be released externally through a per-entry free mask.

Parameters:
- RS_SIZE, 5, number of entries; equals the width of free.
- IDX_W, 5, width of issue_index.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears state immediately).
- packet_in  in  RS_PACKET  incoming instruction:
  - fu: FU_TYPE, 3b (ALU, MULT, LOAD, STORE, BRANCH).
  - inst: 32b.
  - dest_tag, tag1, tag2: REG each = {reg_num 5b, ready 1b}.
- cdb_ready  in  1  CDB broadcast valid this cycle.
- cdb_tag  in  REG  broadcast tag; only reg_num is compared.
- issue_enable  in  1  downstream FU can accept an instruction this cycle.
- free  in  RS_SIZE  free[i]=1 releases entry i at the next posedge (squash/external release).
- allocate_done  out  1  combinational; packet_in will be written at the next posedge.
- ready_issue  out  1  registered; issued_packet/issue_index are valid this cycle.
- issued_packet  out  RS_PACKET  registered; the issued instruction.
- issue_index  out  IDX_W  registered; entry index the packet came from.

Behaviour:
- State per entry: valid bit plus a stored RS_PACKET.

Allocation:
- Request exists iff packet_in.inst != 0; inst==0 is the no-op encoding.
- allocate_done = request && at least one entry is invalid in the current state.
- The target is the lowest-index invalid entry in the current state. Entries freed or issued at the same edge are not reused until the next cycle.
- On allocate_done, at the posedge: entry.valid=1 and entry.packet=packet_in.
- If the same-cycle CDB matches an incoming tag, that tag is stored with ready=1.
- When full, allocate_done=0 and the packet is dropped; upstream must hold it and retry.

Wakeup:
- When cdb_ready=1, at the posedge every valid entry sets tagX.ready=1 for each tag with tagX.reg_num==cdb_tag.reg_num.
- dest_tag is never modified.
- Wakeup and issue take effect one edge apart: an entry woken at edge N is first eligible at edge N+1.

Issue:
- Eligible entry: valid, tag1.ready, tag2.ready (stored values), and free[i]==0.
- At each posedge with issue_enable=1 and at least one eligible entry:
  - Select the lowest index.
  - Drive issued_packet = entry.packet, issue_index = i, ready_issue = 1.
  - Invalidate the entry.
- Otherwise ready_issue=0, issued_packet=0, issue_index=0.
- Latency: a fully ready packet allocated at edge N appears on the outputs after edge N+1, at the earliest.

Free:
- free[i]=1 invalidates entry i at the posedge.
- Free has priority over issue and wakeup for that entry.
- free on an already-invalid entry has no effect.

Reset (reset==0, asynchronous):
- All valid bits cleared; ready_issue=0, issued_packet=0, issue_index=0.
- allocate_done then follows the request alone, since the station is empty.
- Reset mid-operation discards all entries, including one being allocated.

Test Plan:
1. Release reset. Send LOAD inst=54, dest 5, tag1 {0,1}, tag2 {4,1}, issue_enable=1 -> allocate_done=1 that cycle. After the next edge: ready_issue=1, fu=LOAD, inst=54, dest 5, issue_index=0.
2. Send MULT inst=64, tag1 {1,1}, tag2 {5,0} -> allocate_done=1, no issue. Later cdb_ready=1 with cdb_tag 5 -> MULT issues the cycle after the wakeup edge.
3. Wakeup/allocate race: send ALU with tag2 {7,0} while cdb_ready=1, cdb_tag 7 -> entry is stored ready and issues one edge later.
4. Fill all 5 entries with not-ready tags, then send a 6th packet -> allocate_done=0 and state unchanged. Pulse free=5'b00010 -> next packet lands in entry 1.
5. Entries 0 and 2 both ready with issue_enable=0 -> ready_issue stays 0. Raise issue_enable -> entry 0 issues, then entry 2 on the following edge.
6. Drive reset=0 asynchronously mid-operation -> outputs clear immediately and no issue occurs after reset is released.
